// File: rtl/thermal_scan_ctrl.sv
// rtl/thermal_scan_ctrl.sv - byte-stream controller for RO thermal sensor scans and heater groups
module thermal_scan_ctrl #(
  parameter int N_SENSORS = 8,
  parameter int N_HEATERS = 8,
  parameter int CNT_BYTES = 8,
  parameter int SEL_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_in_rd_ready,
  output logic                   data_in_rd_en,
  input  logic [7:0]             data_in,
  input  logic                   data_out_wr_ready,
  output logic                   data_out_wr_en,
  output logic [7:0]             data_out,
  output logic [N_SENSORS-1:0]   ro_sensor_enable,
  output logic [SEL_W-1:0]       sensor_select,
  output logic                   ro_and_timer_reset,
  input  logic [8*CNT_BYTES-1:0] ro_counter_value,
  input  logic [8*CNT_BYTES-1:0] timer_counter_value,
  output logic [N_HEATERS-1:0]   heater_enable,
  input  logic [8*CNT_BYTES-1:0] heater_counter_value
);
  localparam int CNT_W = 8 * CNT_BYTES;
  localparam int REC_W = 8 + 2 * CNT_W;
  localparam int IDX_W = SEL_W + 1;

  localparam logic [7:0] OP_HEAT_ON  = 8'h02;
  localparam logic [7:0] OP_HEAT_OFF = 8'h03;
  localparam logic [7:0] OP_SCAN     = 8'h04;
  localparam logic [7:0] OP_SCAN_N   = 8'h05;

  typedef enum logic [3:0] {
    IDLE, READ_OP, READ_ARGS, HEAT_SET, HEAT_REPORT,
    SCAN_NEXT, MEAS_START, MEAS_WAIT, SEND_REC
  } state_t;

  state_t            state;
  logic [7:0]        opcode;
  logic [7:0]        arg_byte;
  logic [7:0]        arg_cnt;
  logic [7:0]        byte_cnt;
  logic [CNT_W-1:0]  window;
  logic [7:0]        scan_mask;
  logic [7:0]        rounds;
  logic [IDX_W-1:0]  idx;
  logic [SEL_W-1:0]  cur_sel;
  logic [REC_W-1:0]  tx_sr;
  logic              gap;
  logic              wr_ready_q;

  logic              found;
  logic [SEL_W-1:0]  next_i;
  logic [CNT_W-1:0]  win_eff;
  logic              tx_fire;

  // Descending walk so the lowest qualifying index is the one left standing.
  always_comb begin
    found  = 1'b0;
    next_i = '0;
    for (int k = N_SENSORS - 1; k >= 0; k--) begin
      if (scan_mask[k] && (IDX_W'(k) >= idx)) begin
        found  = 1'b1;
        next_i = SEL_W'(k);
      end
    end
  end

  assign win_eff = (window == '0) ? CNT_W'(1) : window;
  assign tx_fire = !gap && data_out_wr_ready && wr_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      opcode             <= '0;
      arg_byte           <= '0;
      arg_cnt            <= '0;
      byte_cnt           <= '0;
      window             <= '0;
      scan_mask          <= '0;
      rounds             <= '0;
      idx                <= '0;
      cur_sel            <= '0;
      tx_sr              <= '0;
      gap                <= 1'b0;
      wr_ready_q         <= 1'b0;
      data_in_rd_en      <= 1'b0;
      data_out_wr_en     <= 1'b0;
      data_out           <= '0;
      ro_sensor_enable   <= '0;
      sensor_select      <= '0;
      ro_and_timer_reset <= 1'b0;
      heater_enable      <= '0;
    end else begin
      data_in_rd_en      <= 1'b0;
      data_out_wr_en     <= 1'b0;
      ro_and_timer_reset <= 1'b0;
      gap                <= 1'b0;
      wr_ready_q         <= data_out_wr_ready;
      case (state)
        IDLE: state <= READ_OP;
        READ_OP: begin
          if (!gap && data_in_rd_ready) begin
            data_in_rd_en <= 1'b1;
            gap           <= 1'b1;
            opcode        <= data_in;
            arg_cnt       <= '0;
            case (data_in)
              OP_HEAT_ON, OP_SCAN, OP_SCAN_N: state <= READ_ARGS;
              OP_HEAT_OFF: begin
                heater_enable <= '0;
                tx_sr         <= {heater_counter_value, {(REC_W - CNT_W){1'b0}}};
                byte_cnt      <= '0;
                state         <= HEAT_REPORT;
              end
              default: state <= IDLE;
            endcase
          end
        end
        READ_ARGS: begin
          if (!gap && data_in_rd_ready) begin
            data_in_rd_en <= 1'b1;
            gap           <= 1'b1;
            arg_cnt       <= arg_cnt + 8'd1;
            if (opcode == OP_HEAT_ON) begin
              arg_byte <= data_in;
              state    <= HEAT_SET;
            end else if (arg_cnt < 8'(CNT_BYTES)) begin
              window <= (window << 8) | CNT_W'(data_in);
            end else if (arg_cnt == 8'(CNT_BYTES)) begin
              scan_mask <= data_in;
              if (opcode == OP_SCAN) begin
                rounds <= 8'd1;
                idx    <= '0;
                state  <= SCAN_NEXT;
              end
            end else begin
              rounds <= (data_in == 8'd0) ? 8'd1 : data_in;
              idx    <= '0;
              state  <= SCAN_NEXT;
            end
          end
        end
        HEAT_SET: begin
          heater_enable <= arg_byte[N_HEATERS-1:0];
          state         <= IDLE;
        end
        HEAT_REPORT, SEND_REC: begin
          if (tx_fire) begin
            data_out       <= tx_sr[REC_W-1 -: 8];
            data_out_wr_en <= 1'b1;
            gap            <= 1'b1;
            tx_sr          <= tx_sr << 8;
            byte_cnt       <= byte_cnt + 8'd1;
            if (state == HEAT_REPORT) begin
              if (byte_cnt == 8'(CNT_BYTES - 1)) state <= IDLE;
            end else if (byte_cnt == 8'(2 * CNT_BYTES)) begin
              idx   <= IDX_W'(cur_sel) + IDX_W'(1);
              state <= SCAN_NEXT;
            end
          end
        end
        SCAN_NEXT: begin
          if (found) begin
            cur_sel <= next_i;
            state   <= MEAS_START;
          end else if (rounds > 8'd1) begin
            rounds <= rounds - 8'd1;
            idx    <= '0;
          end else begin
            rounds <= '0;
            state  <= IDLE;
          end
        end
        MEAS_START: begin
          sensor_select      <= cur_sel;
          ro_sensor_enable   <= N_SENSORS'(1) << cur_sel;
          ro_and_timer_reset <= 1'b1;
          state              <= MEAS_WAIT;
        end
        MEAS_WAIT: begin
          // The timer still shows its pre-clear value while the clear pulse is out.
          if (!ro_and_timer_reset && (timer_counter_value >= win_eff)) begin
            tx_sr            <= {rounds[0], 4'b0000, 3'(cur_sel), ro_counter_value, timer_counter_value};
            ro_sensor_enable <= '0;
            byte_cnt         <= '0;
            state            <= SEND_REC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_thermal_scan_ctrl.sv
// tb/tb_thermal_scan_ctrl.sv - self-checking bench for thermal_scan_ctrl
module tb_thermal_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_in_rd_ready = 1'b0;
  logic        data_in_rd_en;
  logic [7:0]  data_in = 8'h00;
  logic        data_out_wr_ready = 1'b1;
  logic        data_out_wr_en;
  logic [7:0]  data_out;
  logic [7:0]  ro_sensor_enable;
  logic [2:0]  sensor_select;
  logic        ro_and_timer_reset;
  logic [63:0] ro_counter_value = 64'd0;
  logic [63:0] timer_counter_value = 64'd0;
  logic [7:0]  heater_enable;
  logic [63:0] heater_counter_value = 64'd0;

  thermal_scan_ctrl dut (
    .clk(clk), .rst(rst),
    .data_in_rd_ready(data_in_rd_ready), .data_in_rd_en(data_in_rd_en), .data_in(data_in),
    .data_out_wr_ready(data_out_wr_ready), .data_out_wr_en(data_out_wr_en), .data_out(data_out),
    .ro_sensor_enable(ro_sensor_enable), .sensor_select(sensor_select),
    .ro_and_timer_reset(ro_and_timer_reset), .ro_counter_value(ro_counter_value),
    .timer_counter_value(timer_counter_value), .heater_enable(heater_enable),
    .heater_counter_value(heater_counter_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] window;
    logic [7:0]  mask;
    logic [7:0]  rounds;
    logic [7:0]  arg;
    logic [63:0] hcnt;
    logic [7:0]  exp_heat;
    int          exp_recs;
    logic [7:0]  exp_seen;
  } vec_t;

  localparam int LIMIT = 20000;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  int         pops = 0;
  int         pulses = 0;
  logic [7:0] seen = 8'h00;
  logic       bp = 1'b0;
  logic       rdy_prev = 1'b1;
  logic [63:0] timer_m = 64'd0;

  // External RO/timer counters, RX FIFO and TX sink, all updated away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst || ro_and_timer_reset) timer_m = 64'd0;
    else timer_m = timer_m + 64'd1;
    timer_counter_value = timer_m;
    ro_counter_value    = timer_m * (64'(sensor_select) + 64'd2);
    if (data_in_rd_en) begin
      pops++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    data_in_rd_ready = (rx_q.size() > 0);
    data_in = data_in_rd_ready ? rx_q[0] : 8'h00;
    seen = seen | ro_sensor_enable;
    if (ro_and_timer_reset) pulses++;
    if (data_out_wr_en) begin
      vectors++;
      if (!(data_out_wr_ready && rdy_prev)) begin
        miscompares++;
        $display("FAIL tx_rule: ready=%0b prev_ready=%0b, required both 1", data_out_wr_ready, rdy_prev);
      end
      vectors++;
      if (tx_exp.size() == 0) begin
        miscompares++;
        $display("FAIL tx_extra: got byte %02h, required no byte", data_out);
      end else begin
        e = tx_exp.pop_front();
        if (data_out !== e) begin
          miscompares++;
          $display("FAIL tx_byte: got %02h, required %02h", data_out, e);
        end
      end
    end
    rdy_prev = data_out_wr_ready;
    data_out_wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_val(input logic [63:0] v);
    for (int b = 7; b >= 0; b--) tx_exp.push_back(v[8*b +: 8]);
  endtask

  task automatic push_scan(input logic [63:0] window, input logic [7:0] mask, input int nrounds);
    logic [63:0] w;
    w = (window == 64'd0) ? 64'd1 : window;
    for (int r = nrounds; r >= 1; r--) begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) begin
          tx_exp.push_back({r[0], 4'b0000, 3'(i)});
          push_val(w * 64'(i + 2));
          push_val(w);
        end
      end
    end
  endtask

  task automatic expect_row(input vec_t v);
    case (v.op)
      8'h03: push_val(v.hcnt);
      8'h04: push_scan(v.window, v.mask, 1);
      8'h05: push_scan(v.window, v.mask, (v.rounds == 8'd0) ? 1 : int'(v.rounds));
      default: ;
    endcase
  endtask

  task automatic send_cmd(input vec_t v, output int n);
    rx_q.push_back(v.op);
    n = 1;
    if (v.op == 8'h02) begin
      rx_q.push_back(v.arg);
      n++;
    end
    if (v.op == 8'h04 || v.op == 8'h05) begin
      for (int b = 7; b >= 0; b--) rx_q.push_back(v.window[8*b +: 8]);
      rx_q.push_back(v.mask);
      n += 9;
      if (v.op == 8'h05) begin
        rx_q.push_back(v.rounds);
        n++;
      end
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((rx_q.size() > 0 || tx_exp.size() > 0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 64'(n >= LIMIT), 64'd0);
    repeat (40) @(negedge clk);
  endtask

  task automatic run_row(input vec_t v, input string name);
    int n;
    @(negedge clk);
    pulses = 0;
    seen = 8'h00;
    pops = 0;
    heater_counter_value = v.hcnt;
    expect_row(v);
    send_cmd(v, n);
    wait_done(name);
    chk({name, "_left"}, 64'(tx_exp.size()), 64'd0);
    chk({name, "_heat"}, 64'(heater_enable), 64'(v.exp_heat));
    chk({name, "_pulses"}, 64'(pulses), 64'(v.exp_recs));
    chk({name, "_seen_en"}, 64'(seen), 64'(v.exp_seen));
    chk({name, "_pops"}, 64'(pops), 64'(n));
    tx_exp.delete();
  endtask

  task automatic rst_chk(input string name);
    @(posedge clk);
    #1;
    chk(name, 64'({data_in_rd_en, data_out_wr_en, data_out, ro_sensor_enable,
                   sensor_select, ro_and_timer_reset, heater_enable}), 64'd0);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    int   n;
    tbl[0] = '{8'h02, 64'd0,   8'h00, 8'd0, 8'hA5, 64'd0, 8'hA5, 0, 8'h00};
    tbl[1] = '{8'h03, 64'd0,   8'h00, 8'd0, 8'h00, 64'h0102030405060708, 8'h00, 0, 8'h00};
    tbl[2] = '{8'h02, 64'd0,   8'h00, 8'd0, 8'h3C, 64'd0, 8'h3C, 0, 8'h00};
    tbl[3] = '{8'h04, 64'd100, 8'h05, 8'd0, 8'h00, 64'd0, 8'h3C, 2, 8'h05};
    tbl[4] = '{8'h05, 64'd20,  8'h80, 8'd3, 8'h00, 64'd0, 8'h3C, 3, 8'h80};
    tbl[5] = '{8'h7F, 64'd0,   8'h00, 8'd0, 8'h00, 64'd0, 8'h3C, 0, 8'h00};
    tbl[6] = '{8'h04, 64'd5,   8'h00, 8'd0, 8'h00, 64'd0, 8'h3C, 0, 8'h00};
    tbl[7] = '{8'h05, 64'd0,   8'h12, 8'd0, 8'h00, 64'd0, 8'h3C, 2, 8'h12};
    tbl[8] = '{8'h04, 64'd3,   8'hFF, 8'd0, 8'h00, 64'd0, 8'h3C, 8, 8'hFF};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({data_in_rd_en, data_out_wr_en, data_out, ro_sensor_enable,
                              sensor_select, ro_and_timer_reset, heater_enable}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_row(tbl[i], $sformatf("row%0d", i));

    bp = 1'b1;
    run_row(tbl[3], "backpressure");
    bp = 1'b0;

    v = '{8'h04, 64'd1000, 8'h01, 8'd0, 8'h00, 64'd0, 8'h00, 1, 8'h01};
    expect_row(v);
    send_cmd(v, n);
    n = 0;
    while (ro_sensor_enable == 8'h00 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("meas_wait_timeout", 64'(n >= LIMIT), 64'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    rst_chk("rst_meas_wait");
    rx_q.delete();
    tx_exp.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    v = '{8'h04, 64'd10, 8'h01, 8'd0, 8'h00, 64'd0, 8'h00, 1, 8'h01};
    expect_row(v);
    send_cmd(v, n);
    n = 0;
    while (tx_exp.size() > 14 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("send_rec_timeout", 64'(n >= LIMIT), 64'd0);
    rst = 1'b1;
    rst_chk("rst_send_rec");
    rx_q.delete();
    tx_exp.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    v = '{8'h04, 64'd50, 8'h09, 8'd0, 8'h00, 64'd0, 8'h00, 2, 8'h09};
    run_row(v, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
